// File: rtl/lidar_frame_uart_tx.sv
// LiDAR frame UART transmitter: header (MSB byte first), payload (LSB byte first)
// and optional mod-256 payload checksum, sent as 8N1 characters via an internal baud divider.
module lidar_frame_uart_tx #(
  parameter int CLK_DIV     = 16,
  parameter int HDR_BYTES   = 2,
  parameter int PAY_BYTES   = 6,
  parameter int CHECKSUM_EN = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [8*HDR_BYTES-1:0] header,
  input  logic [8*PAY_BYTES-1:0] payload,
  input  logic                   start,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   tx
);

  localparam int N  = HDR_BYTES + PAY_BYTES + ((CHECKSUM_EN != 0) ? 1 : 0);
  localparam int FW = 8 * N;
  localparam int BW = $clog2(CLK_DIV);
  localparam int IW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [IW-1:0]   byte_idx;
  logic [FW-1:0]   frame_q, frame_load;
  logic [7:0]      csum;
  logic            bit_end, last_byte, accept, done_next;

  assign bit_end   = (baud_cnt == BW'(CLK_DIV - 1));
  assign last_byte = (byte_idx == IW'(N - 1));
  assign accept    = start && (state == IDLE);
  assign ready     = (state == IDLE);
  assign busy      = ~ready;

  // Frame is stored in send order from bit 0 up, so DATA only ever shifts right and sends bit 0.
  always_comb begin
    frame_load = '0;
    csum       = '0;
    for (int unsigned i = 0; i < HDR_BYTES; i++)
      frame_load[8*i +: 8] = header[8*(HDR_BYTES-1-i) +: 8];
    for (int unsigned i = 0; i < PAY_BYTES; i++) begin
      frame_load[8*(HDR_BYTES+i) +: 8] = payload[8*i +: 8];
      csum = csum + payload[8*i +: 8];
    end
    if (CHECKSUM_EN != 0)
      frame_load[FW-1 -: 8] = csum;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:  if (start) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_cnt == 3'd7) state_next = STOP;
      STOP: begin
        if (bit_end) begin
          if (last_byte) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = START;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = frame_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      frame_q  <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      done     <= done_next;
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      if (accept) begin
        frame_q  <= frame_load;
        byte_idx <= '0;
        bit_cnt  <= '0;
      end
      if (state == DATA && bit_end) begin
        frame_q <= frame_q >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == STOP && bit_end && !last_byte)
        byte_idx <= byte_idx + 1'b1;
    end
  end

endmodule
